// File: rtl/tmds_clk_rst_seq_pkg.sv
// Shared types and helpers for the TMDS clock/reset sequencer.
//   state_t         : sequencer FSM states
//   LOSS_CNT_W      : width of the lock-loss event counter
//   max_u/cnt_fits  : elaboration-time helpers for parameter sanity checks
package tmds_clk_rst_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABLE    = 3'd1,
      SER_RUN   = 3'd2,
      ALIGN     = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam int unsigned LOSS_CNT_W = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // True when a cnt_w-bit counter can hold max(a, b).
   function automatic bit cnt_fits(input int unsigned cnt_w,
                                   input int unsigned a,
                                   input int unsigned b);
      longint unsigned lim;
      lim = (cnt_w >= 32) ? 64'hFFFF_FFFF : ((64'd1 << cnt_w) - 64'd1);
      return 64'(max_u(a, b)) <= lim;
   endfunction

endpackage

// File: rtl/tmds_clk_rst_seq_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset (flops clear to 0)
//   d   : asynchronous input
//   q   : input after STAGES flops
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift chain; ff[0] is the only flop that may go metastable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/tmds_clk_rst_seq.sv
// Reset / clock-enable sequencer behind the TMDS PLL, clocked by the serial clock.
// Releases serializer reset after lock has been stable, then pixel-domain reset
// on a pixel boundary, and produces a 1-in-DIV pixel clock enable.
//   clk           : serial clock (PLL output)
//   rst           : asynchronous active-high reset
//   pll_lock      : PLL lock, asynchronous to clk
//   ser_rst       : serializer reset, active-high
//   pix_rst       : pixel-domain reset, active-high
//   pix_ce        : one-cycle pulse every DIV clk cycles
//   ready         : high in RUN
//   lock_loss_cnt : count of lock losses out of RUN, saturating
// Optional: define TMDS_LOCK_LOSS_COUNT_EN to build the lock-loss counter;
// otherwise lock_loss_cnt is tied to zero.
module tmds_clk_rst_seq
   import tmds_clk_rst_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned SER_SETTLE_CYCLES  = 16,
   parameter int unsigned DIV                = 5,
   parameter int unsigned CNT_W              = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_lock,
   output logic                  ser_rst,
   output logic                  pix_rst,
   output logic                  pix_ce,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int unsigned PH_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SER_SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(DIV - 1);

   // Parameter sanity checks at elaboration.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (DIV < 1 || LOCK_STABLE_CYCLES < 1 || SER_SETTLE_CYCLES < 1) begin : g_bad_cycles
      $error("DIV, LOCK_STABLE_CYCLES and SER_SETTLE_CYCLES must be at least 1");
   end
   if (!cnt_fits(CNT_W, LOCK_STABLE_CYCLES, SER_SETTLE_CYCLES)) begin : g_bad_cnt_w
      $error("CNT_W too small for LOCK_STABLE_CYCLES / SER_SETTLE_CYCLES");
   end

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ser_rst_nxt;
   logic             pix_rst_nxt;
   logic             ready_nxt;
   logic [PH_W-1:0]  phase;
   logic             div_clr;
   logic             lock_s;

   // Only consumer of the raw lock input.
   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_lock),
      .q   (lock_s)
   );

   // FSM state and registered reset/ready outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= WAIT_LOCK;
         cnt     <= '0;
         ser_rst <= 1'b1;
         pix_rst <= 1'b1;
         ready   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ser_rst <= ser_rst_nxt;
         pix_rst <= pix_rst_nxt;
         ready   <= ready_nxt;
      end
   end

   // Next-state and next-output logic; lock loss overrides every state but WAIT_LOCK.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      ser_rst_nxt = ser_rst;
      pix_rst_nxt = pix_rst;
      ready_nxt   = ready;

      if (state != WAIT_LOCK && !lock_s) begin
         state_nxt   = WAIT_LOCK;
         cnt_nxt     = '0;
         ser_rst_nxt = 1'b1;
         pix_rst_nxt = 1'b1;
         ready_nxt   = 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               cnt_nxt     = '0;
               ser_rst_nxt = 1'b1;
               pix_rst_nxt = 1'b1;
               ready_nxt   = 1'b0;
               if (lock_s) begin
                  state_nxt = STABLE;
               end
            end
            STABLE: begin
               if (cnt == LOCK_LAST) begin
                  state_nxt   = SER_RUN;
                  cnt_nxt     = '0;
                  ser_rst_nxt = 1'b0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            SER_RUN: begin
               if (cnt == SETTLE_LAST) begin
                  state_nxt = ALIGN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ALIGN: begin
               // Release on the edge that closes a pix_ce cycle.
               if (pix_ce) begin
                  state_nxt   = RUN;
                  pix_rst_nxt = 1'b0;
                  ready_nxt   = 1'b1;
               end
            end
            RUN: begin
               ready_nxt = 1'b1;
            end
            default: begin
               state_nxt = WAIT_LOCK;
            end
         endcase
      end
   end

   // Divider is held while ser_rst is high and cleared on the edge it re-asserts,
   // so the first pix_ce lands exactly DIV cycles after serializer release.
   assign div_clr = ser_rst | ser_rst_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase  <= '0;
         pix_ce <= 1'b0;
      end else if (div_clr) begin
         phase  <= '0;
         pix_ce <= 1'b0;
      end else begin
         pix_ce <= (phase == PH_LAST);
         phase  <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
   end

`ifdef TMDS_LOCK_LOSS_COUNT_EN
   // Saturating count of lock losses that knock the sequencer out of RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_loss_cnt <= '0;
      end else if (state == RUN && !lock_s && lock_loss_cnt != '1) begin
         lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
      end
   end
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_tmds_clk_rst_seq.sv
// Directed self-checking bench for tmds_clk_rst_seq: default instance plus a
// short-timing DIV=4 instance used for cadence and lock-loss counting.
module tb_tmds_clk_rst_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_lock;
   logic       pll_lock2;
   logic       ser_rst, pix_rst, pix_ce, ready;
   logic [7:0] lock_loss_cnt;
   logic       ser_rst4, pix_rst4, pix_ce4, ready4;
   logic [7:0] lock_loss_cnt4;

   int checks   = 0;
   int failures = 0;

`ifdef TMDS_LOCK_LOSS_COUNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   always #5 clk = ~clk;

   tmds_clk_rst_seq u_dut (
      .clk           (clk),
      .rst           (rst),
      .pll_lock      (pll_lock),
      .ser_rst       (ser_rst),
      .pix_rst       (pix_rst),
      .pix_ce        (pix_ce),
      .ready         (ready),
      .lock_loss_cnt (lock_loss_cnt)
   );

   tmds_clk_rst_seq #(
      .DIV                (4),
      .LOCK_STABLE_CYCLES (8),
      .SER_SETTLE_CYCLES  (4)
   ) u_div4 (
      .clk           (clk),
      .rst           (rst),
      .pll_lock      (pll_lock2),
      .ser_rst       (ser_rst4),
      .pix_rst       (pix_rst4),
      .pix_ce        (pix_ce4),
      .ready         (ready4),
      .lock_loss_cnt (lock_loss_cnt4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pll_lock = 1'b0; pll_lock2 = 1'b0;
      tick(); tick(); tick();
      checks++; if (ser_rst !== 1'b1) begin failures++; $display("FAIL reset_ser_rst got=%b exp=1", ser_rst); end
      checks++; if (pix_rst !== 1'b1) begin failures++; $display("FAIL reset_pix_rst got=%b exp=1", pix_rst); end
      checks++; if (pix_ce !== 1'b0) begin failures++; $display("FAIL reset_pix_ce got=%b exp=0", pix_ce); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
      checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL reset_loss_cnt got=%0d exp=0", lock_loss_cnt); end
      checks++; if (ser_rst4 !== 1'b1) begin failures++; $display("FAIL reset_ser_rst4 got=%b exp=1", ser_rst4); end
      checks++; if (ready4 !== 1'b0) begin failures++; $display("FAIL reset_ready4 got=%b exp=0", ready4); end
      rst = 1'b0;
      tick(); tick();
   endtask

   // Raise lock (edge 0 is the next edge), optionally glitch it low for 3 cycles
   // after sample glitch_at, and record when each output first changes.
   task automatic watch_main(input int glitch_at, input int ser_exp, input int ce_exp,
                             input int pix_exp, input string tag);
      int ser_fall = -1, ce_first = -1, pix_fall = -1, rdy_rise = -1;
      int early_ce = 0;
      logic prev_ce = 1'b0, ce_before_pix = 1'b0;
      pll_lock = 1'b1;
      for (int n = 0; n < 2000 && pix_fall < 0; n++) begin
         tick();
         if (n == glitch_at) pll_lock = 1'b0;
         if (glitch_at >= 0 && n == glitch_at + 3) pll_lock = 1'b1;
         if (ser_fall < 0 && ser_rst === 1'b0) ser_fall = n;
         if (ce_first < 0 && pix_ce === 1'b1) ce_first = n;
         if (pix_ce === 1'b1 && ser_rst === 1'b1) early_ce++;
         if (rdy_rise < 0 && ready === 1'b1) rdy_rise = n;
         if (pix_fall < 0 && pix_rst === 1'b0) begin pix_fall = n; ce_before_pix = prev_ce; end
         prev_ce = pix_ce;
      end
      checks++; if (ser_fall != ser_exp) begin failures++; $display("FAIL %s_ser_fall got=%0d exp=%0d", tag, ser_fall, ser_exp); end
      checks++; if (ce_first != ce_exp) begin failures++; $display("FAIL %s_first_ce got=%0d exp=%0d", tag, ce_first, ce_exp); end
      checks++; if (pix_fall != pix_exp) begin failures++; $display("FAIL %s_pix_fall got=%0d exp=%0d", tag, pix_fall, pix_exp); end
      checks++; if (rdy_rise != pix_exp) begin failures++; $display("FAIL %s_ready_rise got=%0d exp=%0d", tag, rdy_rise, pix_exp); end
      checks++; if (ce_before_pix !== 1'b1) begin failures++; $display("FAIL %s_pix_on_ce got=%b exp=1", tag, ce_before_pix); end
      checks++; if (early_ce != 0) begin failures++; $display("FAIL %s_ce_in_reset got=%0d exp=0", tag, early_ce); end
   endtask

   task automatic test_clean_lock();
      watch_main(-1, 1026, 1031, 1047, "clean");
   endtask

   task automatic test_cadence();
      int pulses = 0, last = -1, bad = 0, not_rdy = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (pix_ce === 1'b1) begin
            if (last >= 0 && i - last != 5) bad++;
            last = i;
            pulses++;
         end
         if (ready !== 1'b1) not_rdy++;
      end
      checks++; if (pulses != 200) begin failures++; $display("FAIL cadence_pulses got=%0d exp=200", pulses); end
      checks++; if (bad != 0) begin failures++; $display("FAIL cadence_spacing bad_gaps=%0d exp=0", bad); end
      checks++; if (not_rdy != 0) begin failures++; $display("FAIL cadence_ready_drop got=%0d exp=0", not_rdy); end
   endtask

   task automatic test_lock_loss();
      pll_lock = 1'b0;
      tick(); tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL loss_too_early ready got=%b exp=1", ready); end
      tick();
      checks++; if (ser_rst !== 1'b1) begin failures++; $display("FAIL loss_ser_rst got=%b exp=1", ser_rst); end
      checks++; if (pix_rst !== 1'b1) begin failures++; $display("FAIL loss_pix_rst got=%b exp=1", pix_rst); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL loss_ready got=%b exp=0", ready); end
      checks++; if (pix_ce !== 1'b0) begin failures++; $display("FAIL loss_pix_ce got=%b exp=0", pix_ce); end
      checks++; if (lock_loss_cnt !== 8'(CNT_EN)) begin failures++; $display("FAIL loss_count got=%0d exp=%0d", lock_loss_cnt, CNT_EN); end
      tick(); tick(); tick();
   endtask

   task automatic test_relock();
      watch_main(-1, 1026, 1031, 1047, "relock");
   endtask

   task automatic test_glitch();
      pll_lock = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      watch_main(502, 1532, 1537, 1553, "glitch");
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++; if (ser_rst !== 1'b1) begin failures++; $display("FAIL arst_ser_rst got=%b exp=1", ser_rst); end
      checks++; if (pix_rst !== 1'b1) begin failures++; $display("FAIL arst_pix_rst got=%b exp=1", pix_rst); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b exp=0", ready); end
      checks++; if (pix_ce !== 1'b0) begin failures++; $display("FAIL arst_pix_ce got=%b exp=0", pix_ce); end
      checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL arst_loss_cnt got=%0d exp=0", lock_loss_cnt); end
      pll_lock = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_div4();
      int ser_fall = -1, ce_first = -1, pix_fall = -1;
      int pulses = 0, last = -1, bad = 0;
      pll_lock2 = 1'b1;
      for (int n = 0; n < 100 && pix_fall < 0; n++) begin
         tick();
         if (ser_fall < 0 && ser_rst4 === 1'b0) ser_fall = n;
         if (ce_first < 0 && pix_ce4 === 1'b1) ce_first = n;
         if (pix_fall < 0 && pix_rst4 === 1'b0 && ready4 === 1'b1) pix_fall = n;
      end
      checks++; if (ser_fall != 10) begin failures++; $display("FAIL div4_ser_fall got=%0d exp=10", ser_fall); end
      checks++; if (ce_first != 14) begin failures++; $display("FAIL div4_first_ce got=%0d exp=14", ce_first); end
      checks++; if (pix_fall != 15) begin failures++; $display("FAIL div4_pix_fall got=%0d exp=15", pix_fall); end
      for (int i = 0; i < 200; i++) begin
         tick();
         if (pix_ce4 === 1'b1) begin
            if (last >= 0 && i - last != 4) bad++;
            last = i;
            pulses++;
         end
      end
      checks++; if (pulses != 50) begin failures++; $display("FAIL div4_pulses got=%0d exp=50", pulses); end
      checks++; if (bad != 0) begin failures++; $display("FAIL div4_spacing bad_gaps=%0d exp=0", bad); end
   endtask

   // One full relock to RUN followed by a lock loss on the DIV=4 instance.
   task automatic small_cycle(inout int timeouts);
      int got = 0;
      pll_lock2 = 1'b1;
      for (int n = 0; n < 60 && got == 0; n++) begin
         tick();
         if (ready4 === 1'b1) got = 1;
      end
      if (got == 0) timeouts++;
      pll_lock2 = 1'b0;
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_loss_count();
      int timeouts = 0;
      pll_lock2 = 1'b0;
      tick(); tick(); tick(); tick();
      small_cycle(timeouts);
      small_cycle(timeouts);
      checks++; if (lock_loss_cnt4 !== 8'(3 * CNT_EN)) begin failures++; $display("FAIL count_3 got=%0d exp=%0d", lock_loss_cnt4, 3 * CNT_EN); end
      pll_lock2 = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      checks++; if (ser_rst4 !== 1'b1) begin failures++; $display("FAIL count_in_stable ser_rst got=%b exp=1", ser_rst4); end
      pll_lock2 = 1'b0;
      tick(); tick(); tick(); tick();
      checks++; if (lock_loss_cnt4 !== 8'(3 * CNT_EN)) begin failures++; $display("FAIL count_stable_loss got=%0d exp=%0d", lock_loss_cnt4, 3 * CNT_EN); end
      for (int i = 0; i < 297; i++) small_cycle(timeouts);
      checks++; if (lock_loss_cnt4 !== 8'(255 * CNT_EN)) begin failures++; $display("FAIL count_saturate got=%0d exp=%0d", lock_loss_cnt4, 255 * CNT_EN); end
      checks++; if (timeouts != 0) begin failures++; $display("FAIL count_relock_timeout got=%0d exp=0", timeouts); end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_cadence();
      test_lock_loss();
      test_relock();
      test_glitch();
      test_async_reset();
      test_div4();
      test_loss_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
